// File: rtl/writeback_stage_pkg.sv
// Purpose: shared types and constants for the writeback stage and its load extender.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
// Contents: result-source enum, load funct3 encodings, XLEN legality check.
package writeback_stage_pkg;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_LOAD = 2'd1,
    SRC_PC4  = 2'd2,
    SRC_CSR  = 2'd3
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  function automatic bit xlen_legal(int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Purpose: extract the addressed byte/half/word lane of a load and sign/zero extend it.
// Latency: combinational.
// Backpressure: none.
// Ports: funct3_i (load size/sign), byte_off_i (address low bits), raw_i (aligned word), ext_o (result).
module writeback_stage_load_extend
  import writeback_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [2:0]       funct3_i,
  input  logic [OFF_W-1:0] byte_off_i,
  input  logic [XLEN-1:0]  raw_i,
  output logic [XLEN-1:0]  ext_o
);

  logic [OFF_W-1:0] half_off;
  logic [OFF_W-1:0] word_off;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      word_v;

  // Low offset bits below the access size are ignored; misalignment is trapped upstream.
  assign half_off = byte_off_i & ~OFF_W'(1);
  assign word_off = byte_off_i & ~OFF_W'(3);

  assign byte_v = 8'(raw_i >> {byte_off_i, 3'b000});
  assign half_v = 16'(raw_i >> {half_off, 3'b000});
  assign word_v = 32'(raw_i >> {word_off, 3'b000});

  always_comb begin
    ext_o = raw_i;
    case (funct3_i)
      F3_LB:  ext_o = XLEN'($signed(byte_v));
      F3_LBU: ext_o = XLEN'(byte_v);
      F3_LH:  ext_o = XLEN'($signed(half_v));
      F3_LHU: ext_o = XLEN'(half_v);
      F3_LW:  ext_o = XLEN'($signed(word_v));
      // LWU only exists on RV64; elsewhere the raw word passes through.
      F3_LWU: ext_o = (XLEN == 64) ? XLEN'(word_v) : raw_i;
      F3_LD:  ext_o = raw_i;
      default: ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Purpose: M->W pipeline register with stall/flush, load extension, result mux, gated rf write.
// Latency: one cycle from M inputs to W outputs; result_w_o is combinational from W registers.
// Backpressure: stall_w_i holds W; flush_w_i (wins over stall) clears valid on the next edge.
// Ports: clk_i/reset_ni; M-stage inputs *_m_i (incl. rd_m_i); W outputs result/rd/reg_write/valid.
// Optional: define WRITEBACK_RETIRE_COUNT_EN to add retire_count_o, a wrapping CNT_W counter.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  stall_w_i,
  input  logic                  flush_w_i,
  input  logic                  valid_m_i,
  input  logic                  reg_write_m_i,
  input  logic [1:0]            result_src_m_i,
  input  logic [2:0]            funct3_m_i,
  input  logic [REG_ADDR_W-1:0] rd_m_i,
  input  logic [XLEN-1:0]       alu_result_m_i,
  input  logic [XLEN-1:0]       read_data_m_i,
  input  logic [XLEN-1:0]       pc_plus_4_m_i,
  input  logic [XLEN-1:0]       csr_data_m_i,
  output logic [XLEN-1:0]       result_w_o,
  output logic [REG_ADDR_W-1:0] rd_w_o,
  output logic                  reg_write_w_o,
  output logic                  valid_w_o
`ifdef WRITEBACK_RETIRE_COUNT_EN
  ,
  output logic [CNT_W-1:0]      retire_count_o
`endif
);

  localparam int OFF_W = $clog2(XLEN / 8);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("writeback_stage: XLEN must be 32 or 64");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("writeback_stage: CNT_W must be at least 1");
  end

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    result_src_e           src;
    logic [2:0]            funct3;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       alu;
    logic [XLEN-1:0]       rdata;
    logic [XLEN-1:0]       pc4;
    logic [XLEN-1:0]       csr;
  } w_regs_t;

  w_regs_t         w_q, w_d;
  logic [XLEN-1:0] load_ext;

  always_comb begin
    w_d = w_q;
    if (flush_w_i) begin
      // Only valid matters after a flush; data fields are left as-is.
      w_d.valid = 1'b0;
    end else if (!stall_w_i) begin
      w_d.valid     = valid_m_i;
      w_d.reg_write = reg_write_m_i;
      w_d.src       = result_src_e'(result_src_m_i);
      w_d.funct3    = funct3_m_i;
      w_d.rd        = rd_m_i;
      w_d.alu       = alu_result_m_i;
      w_d.rdata     = read_data_m_i;
      w_d.pc4       = pc_plus_4_m_i;
      w_d.csr       = csr_data_m_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      w_q <= '0;
    end else begin
      w_q <= w_d;
    end
  end

  writeback_stage_load_extend #(
    .XLEN (XLEN),
    .OFF_W(OFF_W)
  ) u_load_extend (
    .funct3_i  (w_q.funct3),
    .byte_off_i(w_q.alu[OFF_W-1:0]),
    .raw_i     (w_q.rdata),
    .ext_o     (load_ext)
  );

  always_comb begin
    result_w_o = w_q.alu;
    case (w_q.src)
      SRC_ALU:  result_w_o = w_q.alu;
      SRC_LOAD: result_w_o = load_ext;
      SRC_PC4:  result_w_o = w_q.pc4;
      SRC_CSR:  result_w_o = w_q.csr;
      default:  result_w_o = w_q.alu;
    endcase
  end

  assign rd_w_o        = w_q.rd;
  assign valid_w_o     = w_q.valid;
  // x0 is hardwired to zero, so a write to it is never issued. A stalled valid
  // instruction keeps the strobe high; rewriting the same value is harmless.
  assign reg_write_w_o = w_q.valid & w_q.reg_write & (w_q.rd != '0);

`ifdef WRITEBACK_RETIRE_COUNT_EN
  logic [CNT_W-1:0] retire_count_q, retire_count_d;

  // An instruction retires when it leaves W; a flush on that edge still counts it.
  always_comb begin
    retire_count_d = retire_count_q;
    if (w_q.valid && !stall_w_i) begin
      retire_count_d = retire_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      retire_count_q <= '0;
    end else begin
      retire_count_q <= retire_count_d;
    end
  end

  assign retire_count_o = retire_count_q;
`else
  // No retire counter state in this build.
`endif

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        stall_w_i, flush_w_i, valid_m_i, reg_write_m_i;
  logic [1:0]  result_src_m_i;
  logic [2:0]  funct3_m_i;
  logic [4:0]  rd_m_i;
  logic [31:0] alu32, rdata32, pc32, csr32;
  logic [63:0] alu64, rdata64, pc64, csr64;

  logic [31:0] result32;
  logic [4:0]  rd32;
  logic        rwe32, valid32;
  logic [63:0] result64;
  logic [4:0]  rd64;
  logic        rwe64, valid64;
`ifdef WRITEBACK_RETIRE_COUNT_EN
  logic [3:0]  cnt32;
  logic [63:0] cnt64;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  writeback_stage #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(4)) u32 (
    .clk_i(clk), .reset_ni(reset_ni), .stall_w_i(stall_w_i), .flush_w_i(flush_w_i),
    .valid_m_i(valid_m_i), .reg_write_m_i(reg_write_m_i), .result_src_m_i(result_src_m_i),
    .funct3_m_i(funct3_m_i), .rd_m_i(rd_m_i), .alu_result_m_i(alu32),
    .read_data_m_i(rdata32), .pc_plus_4_m_i(pc32), .csr_data_m_i(csr32),
    .result_w_o(result32), .rd_w_o(rd32), .reg_write_w_o(rwe32), .valid_w_o(valid32)
`ifdef WRITEBACK_RETIRE_COUNT_EN
    , .retire_count_o(cnt32)
`endif
  );

  writeback_stage #(.XLEN(64), .REG_ADDR_W(5), .CNT_W(64)) u64 (
    .clk_i(clk), .reset_ni(reset_ni), .stall_w_i(stall_w_i), .flush_w_i(flush_w_i),
    .valid_m_i(valid_m_i), .reg_write_m_i(reg_write_m_i), .result_src_m_i(result_src_m_i),
    .funct3_m_i(funct3_m_i), .rd_m_i(rd_m_i), .alu_result_m_i(alu64),
    .read_data_m_i(rdata64), .pc_plus_4_m_i(pc64), .csr_data_m_i(csr64),
    .result_w_o(result64), .rd_w_o(rd64), .reg_write_w_o(rwe64), .valid_w_o(valid64)
`ifdef WRITEBACK_RETIRE_COUNT_EN
    , .retire_count_o(cnt64)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                       input logic [2:0] f3, input logic [4:0] rd);
    valid_m_i = v; reg_write_m_i = rw; result_src_m_i = src; funct3_m_i = f3; rd_m_i = rd;
  endtask

  initial begin
    // Reset with random inputs.
    reset_ni = 1'b0;
    stall_w_i = 1'($urandom); flush_w_i = 1'($urandom);
    drive(1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom), 5'($urandom));
    alu32 = $urandom; rdata32 = $urandom; pc32 = $urandom; csr32 = $urandom;
    alu64 = {$urandom, $urandom}; rdata64 = {$urandom, $urandom};
    pc64 = {$urandom, $urandom}; csr64 = {$urandom, $urandom};
    tick(); tick();
    chk("rst_valid", valid32, 0);
    chk("rst_rwe", rwe32, 0);
    chk("rst_rd", rd32, 0);
    chk("rst_result", result32, 0);
    chk("rst_result64", result64, 0);
`ifdef WRITEBACK_RETIRE_COUNT_EN
    chk("rst_cnt", cnt32, 0);
`endif

    // First instruction after reset.
    reset_ni = 1'b1; stall_w_i = 0; flush_w_i = 0;
    drive(1, 1, 2'd0, 3'b000, 5'd5);
    alu32 = 32'h0000_1234;
    tick();
    chk("first_result", result32, 32'h1234);
    chk("first_rd", rd32, 5);
    chk("first_rwe", rwe32, 1);
    chk("first_valid", valid32, 1);

    // Loads, XLEN=32.
    rdata32 = 32'h80FF_7F01;
    drive(1, 1, 2'd1, F3_LB, 5'd7);  alu32 = 32'd3; tick(); chk("lb_off3", result32, 32'hFFFF_FF80);
    drive(1, 1, 2'd1, F3_LBU, 5'd7); alu32 = 32'd3; tick(); chk("lbu_off3", result32, 32'h0000_0080);
    drive(1, 1, 2'd1, F3_LB, 5'd7);  alu32 = 32'd1; tick(); chk("lb_off1", result32, 32'h0000_007F);
    drive(1, 1, 2'd1, F3_LH, 5'd7);  alu32 = 32'd2; tick(); chk("lh_off2", result32, 32'hFFFF_80FF);
    drive(1, 1, 2'd1, F3_LH, 5'd7);  alu32 = 32'd3; tick(); chk("lh_off3", result32, 32'hFFFF_80FF);
    drive(1, 1, 2'd1, F3_LHU, 5'd7); alu32 = 32'd0; tick(); chk("lhu_off0", result32, 32'h0000_7F01);
    drive(1, 1, 2'd1, F3_LW, 5'd7);  alu32 = 32'd0; tick(); chk("lw", result32, 32'h80FF_7F01);
    drive(1, 1, 2'd1, F3_LWU, 5'd7); alu32 = 32'd0; tick(); chk("lwu_rv32_raw", result32, 32'h80FF_7F01);
    rdata32 = 32'h0000_0080;
    drive(1, 1, 2'd1, F3_LD, 5'd7);  alu32 = 32'd0; tick(); chk("ld_rv32_raw", result32, 32'h0000_0080);

    // Stall holds instruction A while M changes.
    drive(1, 1, 2'd0, 3'b000, 5'd9); alu32 = 32'h0000_AAAA; tick();
    stall_w_i = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1'(i), 0, 2'd2, 3'b000, 5'd3 + 5'(i)); alu32 = 32'h5555_0000 + i; pc32 = 32'h77;
      tick();
      chk("stall_result", result32, 32'h0000_AAAA);
      chk("stall_rd", rd32, 9);
      chk("stall_rwe", rwe32, 1);
    end
    flush_w_i = 1; tick();
    chk("flush_stall_valid", valid32, 0);
    chk("flush_stall_rwe", rwe32, 0);
    stall_w_i = 0; flush_w_i = 0;

    // x0 suppression and other sources.
    drive(1, 1, 2'd2, 3'b000, 5'd0); pc32 = 32'h100; tick();
    chk("x0_result", result32, 32'h100);
    chk("x0_rwe", rwe32, 0);
    chk("x0_valid", valid32, 1);
    drive(1, 1, 2'd3, 3'b000, 5'd4); csr32 = 32'h0000_C5C5; tick();
    chk("csr_result", result32, 32'h0000_C5C5);
    chk("csr_rwe", rwe32, 1);
    drive(1, 0, 2'd3, 3'b000, 5'd4); tick();
    chk("no_regwrite_rwe", rwe32, 0);
    drive(0, 1, 2'd3, 3'b000, 5'd4); tick();
    chk("bubble_valid", valid32, 0);
    chk("bubble_rwe", rwe32, 0);

    // Flush alone invalidates; async reset discards in-flight instruction.
    drive(1, 1, 2'd0, 3'b000, 5'd6); alu32 = 32'h0BAD_F00D; tick();
    flush_w_i = 1; tick(); flush_w_i = 0;
    chk("flush_valid", valid32, 0);
    tick();
    #2 reset_ni = 1'b0;
    #1;
    chk("async_rst_valid", valid32, 0);
    chk("async_rst_result", result32, 0);
    chk("async_rst_rd", rd32, 0);
    reset_ni = 1'b1;

    // XLEN=64 loads.
    rdata64 = 64'h8000_0001_0000_0000;
    drive(1, 1, 2'd1, F3_LWU, 5'd8); alu64 = 64'd4; tick(); chk("lwu64_off4", result64, 64'h0000_0000_8000_0001);
    drive(1, 1, 2'd1, F3_LW, 5'd8);  alu64 = 64'd4; tick(); chk("lw64_off4", result64, 64'hFFFF_FFFF_8000_0001);
    drive(1, 1, 2'd1, F3_LB, 5'd8);  alu64 = 64'd7; tick(); chk("lb64_off7", result64, 64'hFFFF_FFFF_FFFF_FF80);
    drive(1, 1, 2'd1, F3_LD, 5'd8);  alu64 = 64'd0; tick(); chk("ld64", result64, 64'h8000_0001_0000_0000);
    rdata64 = 64'h1234_5678_9ABC_DEF0;
    drive(1, 1, 2'd1, 3'b111, 5'd8); alu64 = 64'd0; tick(); chk("f3_111_raw64", result64, 64'h1234_5678_9ABC_DEF0);
    chk("rwe64", rwe64, 1);

`ifdef WRITEBACK_RETIRE_COUNT_EN
    // Retire counter wrap with CNT_W=4.
    reset_ni = 1'b0; #1; reset_ni = 1'b1;
    stall_w_i = 0; flush_w_i = 0;
    drive(1, 1, 2'd0, 3'b000, 5'd1);
    tick();
    chk("cnt_first", cnt32, 0);
    for (int i = 0; i < 15; i++) tick();
    chk("cnt_15", cnt32, 15);
    stall_w_i = 1; tick(); tick();
    chk("cnt_stall", cnt32, 15);
    stall_w_i = 0; tick();
    chk("cnt_wrap", cnt32, 0);
    flush_w_i = 1; tick(); flush_w_i = 0;
    chk("cnt_flush_counts", cnt32, 1);
    tick();
    chk("cnt_after_flush", cnt32, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
